// File: rtl/dense_argmax_reader.sv
// Reads the dense layer's OUT_COUNT scores back from the outputs RAM, keeps a running signed
// arg-max and presents the winning class on a valid/ack handshake. Option: ARGMAX_SCORE_OUT_EN.
module dense_argmax_reader #(
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 16,
  localparam int AW = $clog2(OUT_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 ram_rd,
  output logic [AW-1:0]        ram_adr,
  input  logic [DATA_SIZE-1:0] ram_dataOut,
  input  logic                 classAck,
  output logic                 classValid,
  output logic [AW-1:0]        classOut
`ifdef ARGMAX_SCORE_OUT_EN
  , output logic [DATA_SIZE-1:0] maxScore
`endif
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(OUT_COUNT - 1);

  state_t                        state_q, state_d;
  logic [AW-1:0]                 cnt_q, cnt_d;
  logic signed [DATA_SIZE-1:0]   best_q, best_d;
  logic [AW-1:0]                 bidx_q, bidx_d;
  logic [AW-1:0]                 cls_q, cls_d;
  logic [AW-1:0]                 idx;
  logic                          take;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_SIZE-1:0]          max_q, max_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      cls_q   <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      cls_q   <= cls_d;
`ifdef ARGMAX_SCORE_OUT_EN
      max_q   <= max_d;
`endif
    end
  end

  // Read data lags the address by one cycle, so the score arriving now belongs to cnt-1
  // (or to the last entry while flushing). Index 0 always seeds the running best.
  always_comb begin
    idx  = (state_q == FLUSH) ? LAST : cnt_q - AW'(1);
    take = (idx == '0) || ($signed(ram_dataOut) > best_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    cls_d   = cls_q;
`ifdef ARGMAX_SCORE_OUT_EN
    max_d   = max_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = READ;
      end
      READ: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q != '0 && take) begin
          best_d = $signed(ram_dataOut);
          bidx_d = idx;
        end
        if (cnt_q == LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (take) begin
          best_d = $signed(ram_dataOut);
          bidx_d = idx;
        end
        cls_d = take ? idx : bidx_q;
`ifdef ARGMAX_SCORE_OUT_EN
        max_d = take ? ram_dataOut : best_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (classAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign ram_rd     = (state_q == READ);
  assign ram_adr    = cnt_q;
  assign classValid = (state_q == DONE);
  assign classOut   = cls_q;
`ifdef ARGMAX_SCORE_OUT_EN
  assign maxScore   = max_q;
`endif

endmodule
